// File: rtl/mat4_vec_sequencer_pkg.sv
// Shared constants and state encoding for the matrix-vector sequencer.
package mat4_vec_sequencer_pkg;
  localparam int DATA_W        = 16;
  localparam int N             = 4;
  localparam int WORDS_PER_JOB = 20;   // 16 matrix words + 4 vector words
  localparam int WCNT_W        = 5;
  localparam int VEC_BASE      = N * N; // buffer slot of v[0]

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;
endpackage

// File: rtl/mat4_vec_buffer.sv
// 20x16 job buffer: one write port by word count, one matrix-row read and
// one vector read. Contents are never cleared; every slot is rewritten
// before a job reads it, so no reset is needed on the storage.
module mat4_vec_buffer
  import mat4_vec_sequencer_pkg::*;
(
  input  logic                          clk,
  input  logic                          we,
  input  logic [WCNT_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [1:0]                    rrow,
  output logic [N-1:0][DATA_W-1:0]      row_data,
  output logic [N-1:0][DATA_W-1:0]      vec_data
);
  logic [WORDS_PER_JOB-1:0][DATA_W-1:0] mem_q, mem_d;

  // Next storage contents: write the accepted word into its slot.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage flops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Per-lane read taps: row r lives at slots 4r..4r+3, vector at 16..19.
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [1:0] COL = 2'(g);
    assign row_data[g] = mem_q[{rrow, COL}];
    assign vec_data[g] = mem_q[VEC_BASE + g];
  end
endmodule

// File: rtl/mat4_vec_sequencer.sv
// Streams in a 4x4 matrix and vector, drives one row per cycle into the
// external dot-product unit, captures the four scalars and streams them out.
module mat4_vec_sequencer #(
  parameter int DATA_W = 16,
  parameter int N      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] dp_a0,
  output logic [DATA_W-1:0] dp_a1,
  output logic [DATA_W-1:0] dp_a2,
  output logic [DATA_W-1:0] dp_a3,
  output logic [DATA_W-1:0] dp_b0,
  output logic [DATA_W-1:0] dp_b1,
  output logic [DATA_W-1:0] dp_b2,
  output logic [DATA_W-1:0] dp_b3,
  input  logic [DATA_W-1:0] dp_c,
  output logic              busy
);
  import mat4_vec_sequencer_pkg::*;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_JOB - 1);
  localparam logic [1:0]        LAST_IDX  = 2'(N - 1);

  state_e                      state_q, state_d;
  logic [WCNT_W-1:0]           wcnt_q, wcnt_d;
  logic [1:0]                  r_q, r_d;
  logic [1:0]                  ocnt_q, ocnt_d;
  logic [N-1:0][DATA_W-1:0]    res_q, res_d;
  logic [N-1:0][DATA_W-1:0]    row_data, vec_data, dp_a, dp_b;
  logic                        in_fire, out_fire, computing;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUTPUT);
  assign computing = (state_q == ST_COMPUTE);
  assign busy      = !in_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? res_q[ocnt_q] : '0;
  assign out_last  = out_valid && (ocnt_q == LAST_IDX);

  mat4_vec_buffer u_buf (
    .clk      (clk),
    .we       (in_fire),
    .waddr    (wcnt_q),
    .wdata    (in_data),
    .rrow     (r_q),
    .row_data (row_data),
    .vec_data (vec_data)
  );

  // Operands are held at zero outside COMPUTE so the dot-product unit idles.
  assign dp_a  = computing ? row_data : '0;
  assign dp_b  = computing ? vec_data : '0;
  assign dp_a0 = dp_a[0];
  assign dp_a1 = dp_a[1];
  assign dp_a2 = dp_a[2];
  assign dp_a3 = dp_a[3];
  assign dp_b0 = dp_b[0];
  assign dp_b1 = dp_b[1];
  assign dp_b2 = dp_b[2];
  assign dp_b3 = dp_b[3];

  // Next-state logic: load 20 words, compute 4 rows, emit 4 results.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    r_d     = r_q;
    ocnt_d  = ocnt_q;
    res_d   = res_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          if (wcnt_q == LAST_WORD) begin
            wcnt_d  = '0;
            r_d     = '0;
            state_d = ST_COMPUTE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        res_d[r_q] = dp_c;
        r_d        = r_q + 1'b1;
        if (r_q == LAST_IDX) begin
          ocnt_d  = '0;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_fire) begin
          ocnt_d = ocnt_q + 1'b1;
          if (ocnt_q == LAST_IDX) begin
            wcnt_d  = '0;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State, counters and result registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      r_q     <= '0;
      ocnt_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      r_q     <= r_d;
      ocnt_q  <= ocnt_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_mat4_vec_sequencer.sv
// Self-checking bench: a job-level model predicts every cycle's handshake,
// operand and result outputs; scenario results are pinned with literals.
module tb_mat4_vec_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [15:0] in_data, out_data, dp_c;
  logic [15:0] dp_a0, dp_a1, dp_a2, dp_a3, dp_b0, dp_b1, dp_b2, dp_b3;
  logic [31:0] psum;
  logic [15:0] da[4], db[4];

  mat4_vec_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .dp_a0(dp_a0), .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_a3(dp_a3),
    .dp_b0(dp_b0), .dp_b1(dp_b1), .dp_b2(dp_b2), .dp_b3(dp_b3),
    .dp_c(dp_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural dot-product unit.
  assign psum = 32'(dp_a0) * 32'(dp_b0) + 32'(dp_a1) * 32'(dp_b1)
              + 32'(dp_a2) * 32'(dp_b2) + 32'(dp_a3) * 32'(dp_b3);
  assign dp_c = psum[15:0];
  assign da   = '{dp_a0, dp_a1, dp_a2, dp_a3};
  assign db   = '{dp_b0, dp_b1, dp_b2, dp_b3};

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- job-level model ----------------
  bit          chk_en = 0;
  logic [15:0] mw[20];      // words of the job being loaded
  logic [15:0] cur_w[20];   // words of the job being computed
  int          mcnt = 0;    // words accepted so far
  int          comp_left = 0;
  logic [15:0] eq[$];       // results still to be delivered
  bit          m_busy, m_ov;
  int          m_row;
  logic [15:0] pop_tmp;
  longint      acc;

  // Compare every output against the model, then advance the model by
  // what the coming edge will do.
  always @(negedge clk) begin
    if (chk_en) begin
      m_busy = (comp_left > 0) || (eq.size() > 0);
      m_ov   = (comp_left == 0) && (eq.size() > 0);
      chk("in_ready", in_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_data", out_data, eq[0]);
        chk("out_last", out_last, eq.size() == 1);
      end
      m_row = 4 - comp_left;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("dp_a%0d", i), da[i], (comp_left > 0) ? cur_w[m_row*4+i] : 16'h0);
        chk($sformatf("dp_b%0d", i), db[i], (comp_left > 0) ? cur_w[16+i] : 16'h0);
      end
      if (rst) begin
        mcnt = 0; comp_left = 0; eq.delete();
      end else if (comp_left > 0) begin
        comp_left--;
      end else if (eq.size() > 0) begin
        if (out_ready) pop_tmp = eq.pop_front();
      end else if (in_valid) begin
        mw[mcnt] = in_data;
        mcnt++;
        if (mcnt == 20) begin
          for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) acc += longint'(mw[r*4+c]) * longint'(mw[16+c]);
            eq.push_back(acc[15:0]);
          end
          cur_w = mw;
          comp_left = 4;
          mcnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] jw[20];
  logic [15:0] got[4];
  logic        got_last[4];
  int          acc_cyc, first_cyc;
  logic [15:0] held;

  task automatic send_job(input int nwords, input int gap_pct);
    int t;
    for (int i = 0; i < nwords; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = jw[i];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (!in_ready) begin chk("send_timeout", in_ready, 1); in_valid = 1'b0; return; end
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input int nwords, input int stall_idx, input int stall_len);
    int t;
    for (int k = 0; k < nwords; k++) begin
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          if (s == 0) held = out_data;
          else chk("stall_hold", out_data, held);
          chk("stall_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 200) begin @(negedge clk); t++; end
      if (!out_valid) begin chk("recv_timeout", out_valid, 1); return; end
      if (k == 0) first_cyc = cyc;
      got[k]      = out_data;
      got_last[k] = out_last;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_res(input string name, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_y%0d", name, k), got[k], e[k]);
      chk($sformatf("%s_last%0d", name, k), got_last[k], k == 3);
    end
  endtask

  task automatic set_ident(input logic [15:0] v0, input logic [15:0] v1,
                           input logic [15:0] v2, input logic [15:0] v3);
    for (int i = 0; i < 16; i++) jw[i] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
    jw[16] = v0; jw[17] = v1; jw[18] = v2; jw[19] = v3;
  endtask

  task automatic set_random();
    for (int i = 0; i < 20; i++) jw[i] = 16'($urandom);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dp_a0", dp_a0, 0);
    @(posedge clk); #1;

    // Identity matrix, v = 1..4, no gaps; check latency from v[3].
    set_ident(16'd1, 16'd2, 16'd3, 16'd4);
    send_job(20, 0);
    recv(4, -1, 0);
    check_res("ident", 16'd1, 16'd2, 16'd3, 16'd4);
    chk("latency", first_cyc - acc_cyc, 4);

    // M[r][c] = r+1, v = 1s: row sums.
    for (int i = 0; i < 16; i++) jw[i] = 16'(i / 4 + 1);
    for (int i = 16; i < 20; i++) jw[i] = 16'd1;
    send_job(20, 0);
    recv(4, -1, 0);
    check_res("rows", 16'd4, 16'd8, 16'd12, 16'd16);

    // Random words with input gaps, 7-cycle stall on y[1].
    set_random();
    send_job(20, 40);
    recv(4, 1, 7);

    // Abort after 9 words, then a clean job.
    set_random();
    send_job(9, 20);
    pulse_reset();
    set_ident(16'd5, 16'd6, 16'd7, 16'd8);
    send_job(20, 0);
    recv(4, -1, 0);
    check_res("abort", 16'd5, 16'd6, 16'd7, 16'd8);

    // Reset during OUTPUT after y[1], then a fresh random job.
    set_random();
    send_job(20, 0);
    recv(2, -1, 0);
    pulse_reset();
    set_random();
    send_job(20, 30);
    recv(4, 2, 3);

    // Overflow wrap, then buffer reuse.
    for (int i = 0; i < 20; i++) jw[i] = 16'h0100;
    send_job(20, 0);
    recv(4, -1, 0);
    check_res("wrap", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    set_ident(16'd9, 16'd9, 16'd9, 16'd9);
    send_job(20, 0);
    recv(4, -1, 0);
    check_res("reuse", 16'd9, 16'd9, 16'd9, 16'd9);

    // A few more random jobs with gaps and stalls.
    for (int j = 0; j < 4; j++) begin
      set_random();
      send_job(20, 25);
      recv(4, j % 4, 2 + j);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
